// File: rtl/masked_mem_rf_pkg.sv
// Shared types and helpers for the masked memory register file.
package masked_mem_rf_pkg;

    typedef enum logic [0:0] {S_RUN, S_CLEAR} state_e;

    // Widest word merge_mask can handle; callers cast to and from their own width.
    localparam int unsigned MERGE_W = 256;

    function automatic logic [MERGE_W-1:0] merge_mask(input logic [MERGE_W-1:0] old_word,
                                                      input logic [MERGE_W-1:0] data,
                                                      input logic [MERGE_W-1:0] mask);
        return (old_word & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/masked_mem_rf_clear_seq.sv
// Clear sequencer: walks every entry writing zero after reset or on a clear request.
module masked_mem_rf_clear_seq
    import masked_mem_rf_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    localparam int unsigned ADDR_W        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              init_busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            clr_cnt_q <= '0;
        end else begin
            unique case (state_q)
                S_CLEAR: begin
                    if (clr_cnt_q == LAST) begin
                        state_q   <= S_RUN;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    end
                end
                S_RUN: begin
                    if (clear) begin
                        state_q   <= S_CLEAR;
                        clr_cnt_q <= '0;
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign init_busy = (state_q == S_CLEAR);
    assign clr_we    = init_busy;
    assign clr_addr  = clr_cnt_q;

endmodule

// File: rtl/masked_mem_rf.sv
// Parametrised memory with per-bit write masks, registered read and optional write bypass.
module masked_mem_rf
    import masked_mem_rf_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned DEPTH          = 4,
    parameter bit          BYPASS         = 1'b1,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    localparam int unsigned ADDR_W        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [WIDTH-1:0]  wr_mask,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              init_busy
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              run;
    logic              wr_ok;
    logic              rd_ok;
    logic              wr_go;
    logic              rd_go;
    logic [WIDTH-1:0]  wr_word;
    logic [WIDTH-1:0]  rd_word;

    masked_mem_rf_clear_seq #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_busy (init_busy)
    );

    // Addresses past DEPTH exist only when DEPTH is not a power of two.
    assign run   = !init_busy && !rst;
    assign wr_ok = 32'(wr_addr) < DEPTH;
    assign rd_ok = 32'(rd_addr) < DEPTH;
    assign wr_go = run && wr_en && wr_ok;
    assign rd_go = run && rd_en;

    assign wr_word = WIDTH'(merge_mask(MERGE_W'(mem_q[wr_addr]), MERGE_W'(wr_data),
                                       MERGE_W'(wr_mask)));

    always_comb begin
        rd_word = rd_ok ? mem_q[rd_addr] : '0;
        if (BYPASS && wr_go && (wr_addr == rd_addr)) begin
            rd_word = wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_go) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_go;
            if (rd_go) begin
                rd_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_masked_mem_rf.sv
// Randomised and directed bench: two instances (4-deep bypass, 3-deep no bypass) vs a model.
module tb_masked_mem_rf;

    logic       clk = 1'b0;
    logic       rst, clear, wr_en, rd_en;
    logic [1:0] wr_addr, rd_addr;
    logic [7:0] wr_data, wr_mask;
    logic [7:0] rd_data_a, rd_data_b;
    logic       rd_valid_a, rd_valid_b, busy_a, busy_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    masked_mem_rf #(
        .WIDTH          (8),
        .DEPTH          (4),
        .BYPASS         (1'b1),
        .CLEAR_ON_RESET (1'b1)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data_a),
        .rd_valid  (rd_valid_a),
        .init_busy (busy_a)
    );

    masked_mem_rf #(
        .WIDTH          (8),
        .DEPTH          (3),
        .BYPASS         (1'b0),
        .CLEAR_ON_RESET (1'b1)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data_b),
        .rd_valid  (rd_valid_b),
        .init_busy (busy_b)
    );

    // Reference model: contents are zeroed as a whole when a clear starts; busy counts down.
    int         depth_m [2] = '{4, 3};
    bit         byp_m   [2] = '{1'b1, 1'b0};
    logic [7:0] mem_m   [2][4];
    int         busy_m  [2];
    logic [7:0] rdd_m   [2];
    logic       rdv_m   [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        logic       hit;
        logic [7:0] merged;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                rdd_m[d]  = 8'h00;
                rdv_m[d]  = 1'b0;
                busy_m[d] = depth_m[d];
                for (int k = 0; k < 4; k++) mem_m[d][k] = 8'h00;
            end else if (busy_m[d] > 0) begin
                busy_m[d]--;
                rdv_m[d] = 1'b0;
            end else begin
                hit    = wr_en && (int'(wr_addr) < depth_m[d]);
                merged = hit ? ((mem_m[d][wr_addr] & ~wr_mask) | (wr_data & wr_mask)) : 8'h00;
                rdv_m[d] = rd_en;
                if (rd_en) begin
                    if (int'(rd_addr) >= depth_m[d]) rdd_m[d] = 8'h00;
                    else if (byp_m[d] && hit && wr_addr == rd_addr) rdd_m[d] = merged;
                    else rdd_m[d] = mem_m[d][rd_addr];
                end
                if (hit) mem_m[d][wr_addr] = merged;
                if (clear) begin
                    busy_m[d] = depth_m[d];
                    for (int k = 0; k < 4; k++) mem_m[d][k] = 8'h00;
                end
            end
        end
        @(posedge clk);
        #1;
        check_eq("rd_data_a", rd_data_a, rdd_m[0]);
        check_eq("rd_valid_a", rd_valid_a, rdv_m[0]);
        check_eq("busy_a", busy_a, busy_m[0] > 0);
        check_eq("rd_data_b", rd_data_b, rdd_m[1]);
        check_eq("rd_valid_b", rd_valid_b, rdv_m[1]);
        check_eq("busy_b", busy_b, busy_m[1] > 0);
    endtask

    task automatic idle();
        clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] dt, input logic [7:0] m);
        idle();
        wr_en = 1'b1; wr_addr = a; wr_data = dt; wr_mask = m;
        step();
    endtask

    task automatic rd(input logic [1:0] a);
        idle();
        rd_en = 1'b1; rd_addr = a;
        step();
    endtask

    task automatic count_busy(input string tag, input int exp);
        int n = 0;
        while (busy_a === 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_eq(tag, n, exp);
    endtask

    initial begin
        rst = 1'b1; wr_addr = '0; rd_addr = '0; wr_data = '0; wr_mask = '0;
        idle();
        step();
        step();
        rst = 1'b0;
        count_busy("busy_after_reset", 4);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            check_eq("reset_read", rd_data_a, 8'h00);
        end

        wr(2'd2, 8'hFF, 8'hFF);
        wr(2'd2, 8'h00, 8'h0F);
        rd(2'd2);
        check_eq("mask_merge", rd_data_a, 8'hF0);

        wr(2'd1, 8'h11, 8'hFF);
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hAA; wr_mask = 8'hFF;
        rd_en = 1'b1; rd_addr = 2'd1;
        step();
        check_eq("bypass_new", rd_data_a, 8'hAA);
        check_eq("nobypass_old", rd_data_b, 8'h11);
        rd(2'd1);
        check_eq("after_bypass_a", rd_data_a, 8'hAA);
        check_eq("after_bypass_b", rd_data_b, 8'hAA);

        for (int a = 0; a < 4; a++) wr(2'(a), 8'h5A, 8'hFF);
        idle();
        clear = 1'b1;
        step();
        clear = 1'b0;
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF; wr_mask = 8'hFF;
        rd_en = 1'b1; rd_addr = 2'd0;
        count_busy("busy_runtime_clear", 4);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            check_eq("clear_read", rd_data_a, 8'h00);
        end

        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy("busy_reset_mid_clear", 4);

        wr(2'd0, 8'h01, 8'hFF);
        wr(2'd3, 8'h77, 8'hFF);
        rd(2'd3);
        check_eq("oor_data", rd_data_b, 8'h00);
        check_eq("oor_valid", rd_valid_b, 1'b1);
        rd(2'd0);
        check_eq("oor_untouched", rd_data_b, 8'h01);

        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            clear   = ($urandom_range(0, 49) == 0);
            wr_en   = $urandom_range(0, 1) == 1;
            rd_en   = $urandom_range(0, 3) != 0;
            wr_addr = 2'($urandom_range(0, 3));
            rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 2'($urandom_range(0, 3));
            wr_data = 8'($urandom);
            wr_mask = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
